// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the request-type enum carried in the output request register and
// the default parameter values used by the top and the tag FIFO.
package mem_port_arb_pkg;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_TAG_DEPTH = 8;

    // Kind of request currently held in the one-entry output register.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WR   = 2'd1,
        REQ_RD   = 2'd2
    } req_kind_e;

endpackage

// File: rtl/mem_port_arb_tag_fifo.sv
// Tag FIFO: remembers which lane issued each outstanding read so that the
// in-order read returns from memc can be routed back to the right lane.
// Ports:
//   clk, reset_poweron   clock, asynchronous active-low reset
//   push, push_tag       store a lane index (ignored when full)
//   pop                  discard the head entry (ignored when empty)
//   full, empty, head    status and oldest stored lane index
module mem_port_arb_tag_fifo #(
    parameter int TAG_DEPTH = 8,
    parameter int TAG_W     = 2
) (
    input  logic             clk,
    input  logic             reset_poweron,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    logic [TAG_W-1:0] tags [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(TAG_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = tags[rd_ptr];

    // Pointers wrap naturally because TAG_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) tags[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter merging NUM_LANES DMA read/write requesters onto one
// memc port, with in-order read returns routed back via a tag FIFO.
// Ports:
//   clk, reset_poweron              clock, asynchronous active-low reset
//   dma__arb__write_*               per-lane write request and payload
//   arb__dma__write_ready           per-lane write accept
//   dma__arb__read_*                per-lane read request and address
//   arb__dma__read_ready            per-lane read accept
//   arb__dma__read_data_valid/data  routed read return
//   arb__memc__*                    shared registered request port
//   memc__arb__ready                memc accepts the presented request
//   memc__arb__read_data_valid/data in-order read return from memc
//   err_orphan                      sticky: a return arrived with no read outstanding
//
// Handshake: a transfer happens on a channel in any cycle where its valid and
// ready are both high; valid never depends on ready, and a presented memc
// request stays unchanged until memc__arb__ready is seen with it.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset_poweron,
    input  logic [NUM_LANES-1:0]             dma__arb__write_valid,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0] dma__arb__write_address,
    input  logic [NUM_LANES-1:0][DATA_W-1:0] dma__arb__write_data,
    output logic [NUM_LANES-1:0]             arb__dma__write_ready,
    input  logic [NUM_LANES-1:0]             dma__arb__read_valid,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0] dma__arb__read_address,
    output logic [NUM_LANES-1:0]             arb__dma__read_ready,
    output logic [NUM_LANES-1:0]             arb__dma__read_data_valid,
    output logic [DATA_W-1:0]                arb__dma__read_data,
    output logic                             arb__memc__write_valid,
    output logic [ADDR_W-1:0]                arb__memc__write_address,
    output logic [DATA_W-1:0]                arb__memc__write_data,
    output logic                             arb__memc__read_valid,
    output logic [ADDR_W-1:0]                arb__memc__read_address,
    input  logic                             memc__arb__ready,
    input  logic                             memc__arb__read_data_valid,
    input  logic [DATA_W-1:0]                memc__arb__read_data,
    output logic                             err_orphan
);

    localparam int LANE_W = $clog2(NUM_LANES);

    req_kind_e             out_kind;
    logic [ADDR_W-1:0]     out_addr;
    logic [DATA_W-1:0]     out_data;
    logic [LANE_W-1:0]     rr_ptr;

    logic [NUM_LANES-1:0]  eligible;
    logic                  grant_found;
    logic [LANE_W-1:0]     grant_lane;
    logic [LANE_W-1:0]     cand;
    logic                  grant_is_wr;
    logic                  arb_en;
    logic                  take;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LANE_W-1:0]     fifo_head;

    // A full tag FIFO only masks reads; a lane with a write stays eligible.
    assign eligible    = dma__arb__write_valid |
                         (dma__arb__read_valid & {NUM_LANES{!fifo_full}});

    // Arbitrate only when the output register is free or drains this cycle.
    // Reset is folded in so no lane sees ready while reset is held.
    assign arb_en      = reset_poweron && ((out_kind == REQ_NONE) || memc__arb__ready);
    assign take        = arb_en && grant_found;
    assign grant_is_wr = dma__arb__write_valid[grant_lane];

    // First eligible lane at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = '0;
        cand        = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = LANE_W'((int'(rr_ptr) + k) % NUM_LANES);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    always_comb begin
        arb__dma__write_ready = '0;
        arb__dma__read_ready  = '0;
        if (take) begin
            if (grant_is_wr) arb__dma__write_ready[grant_lane] = 1'b1;
            else             arb__dma__read_ready[grant_lane]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            out_kind   <= REQ_NONE;
            out_addr   <= '0;
            out_data   <= '0;
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (arb_en) begin
                if (grant_found) begin
                    out_kind <= grant_is_wr ? REQ_WR : REQ_RD;
                    out_addr <= grant_is_wr ? dma__arb__write_address[grant_lane]
                                            : dma__arb__read_address[grant_lane];
                    if (grant_is_wr) out_data <= dma__arb__write_data[grant_lane];
                    rr_ptr   <= (grant_lane == LANE_W'(NUM_LANES - 1)) ? '0
                                                                       : grant_lane + 1'b1;
                end else begin
                    out_kind <= REQ_NONE;
                end
            end
            if (memc__arb__read_data_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign arb__memc__write_valid   = (out_kind == REQ_WR);
    assign arb__memc__write_address = out_addr;
    assign arb__memc__write_data    = out_data;
    assign arb__memc__read_valid    = (out_kind == REQ_RD);
    assign arb__memc__read_address  = out_addr;

    // Returns are in order, so the FIFO head names the owning lane.
    always_comb begin
        arb__dma__read_data_valid = '0;
        if (memc__arb__read_data_valid && !fifo_empty)
            arb__dma__read_data_valid[fifo_head] = 1'b1;
    end
    assign arb__dma__read_data = memc__arb__read_data;

    mem_port_arb_tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH),
        .TAG_W     (LANE_W)
    ) u_tag_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (take && !grant_is_wr),
        .push_tag      (grant_lane),
        .pop           (memc__arb__read_data_valid),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .head          (fifo_head)
    );

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

    logic              clk = 1'b0;
    logic              reset_poweron = 1'b0;
    logic [3:0]        w_valid = '0;
    logic [3:0][23:0]  w_addr = '0;
    logic [3:0][31:0]  w_data = '0;
    logic [3:0]        w_ready;
    logic [3:0]        r_valid = '0;
    logic [3:0][23:0]  r_addr = '0;
    logic [3:0]        r_ready;
    logic [3:0]        d_rvalid;
    logic [31:0]       d_rdata;
    logic              mw_valid;
    logic [23:0]       mw_addr;
    logic [31:0]       mw_data;
    logic              mr_valid;
    logic [23:0]       mr_addr;
    logic              mem_ready = 1'b0;
    logic              mem_rdv = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    mem_port_arb dut (
        .clk                        (clk),
        .reset_poweron              (reset_poweron),
        .dma__arb__write_valid      (w_valid),
        .dma__arb__write_address    (w_addr),
        .dma__arb__write_data       (w_data),
        .arb__dma__write_ready      (w_ready),
        .dma__arb__read_valid       (r_valid),
        .dma__arb__read_address     (r_addr),
        .arb__dma__read_ready       (r_ready),
        .arb__dma__read_data_valid  (d_rvalid),
        .arb__dma__read_data        (d_rdata),
        .arb__memc__write_valid     (mw_valid),
        .arb__memc__write_address   (mw_addr),
        .arb__memc__write_data      (mw_data),
        .arb__memc__read_valid      (mr_valid),
        .arb__memc__read_address    (mr_addr),
        .memc__arb__ready           (mem_ready),
        .memc__arb__read_data_valid (mem_rdv),
        .memc__arb__read_data       (mem_rdata),
        .err_orphan                 (err_orphan)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write and read must never be presented to memc together
    always @(negedge clk) begin
        if (reset_poweron) begin
            checks++;
            if (mw_valid && mr_valid) begin
                errors++;
                $display("FAIL wr_rd_exclusive: got write_valid=%b read_valid=%b, required not both", mw_valid, mr_valid);
            end
        end
    end

    // driver tasks
    task automatic drive_idle();
        w_valid   = '0;
        r_valid   = '0;
        mem_rdv   = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_poweron = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_poweron = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        w_valid = 4'hF;
        r_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (w_ready !== 4'b0 || r_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_ready: got w=%b r=%b, required 0000 0000", w_ready, r_ready);
        end
        checks++;
        if (mw_valid !== 1'b0 || mr_valid !== 1'b0 || d_rvalid !== 4'b0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got mw=%b mr=%b drv=%b err=%b, required all 0", mw_valid, mr_valid, d_rvalid, err_orphan);
        end
        drive_idle();
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ready;
        logic [23:0] exp_addr;
        logic [31:0] exp_data;
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_addr[i] = 24'(32'h100 + i);
            w_data[i] = 32'hA0 + 32'(i);
        end
        w_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_ready = 4'b0001 << (k % 4);
            checks++;
            if (w_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: got %b, required %b", k, w_ready, exp_ready);
            end
            if (k > 0) begin
                exp_addr = 24'(32'h100 + (k - 1) % 4);
                exp_data = 32'hA0 + 32'((k - 1) % 4);
                checks++;
                if (mw_valid !== 1'b1 || mw_addr !== exp_addr || mw_data !== exp_data) begin
                    errors++;
                    $display("FAIL rr_memc_write cycle %0d: got v=%b a=%h d=%h, required v=1 a=%h d=%h",
                             k, mw_valid, mw_addr, mw_data, exp_addr, exp_data);
                end
            end
            next_cycle();
        end
        w_valid = '0;
        @(negedge clk);
        checks++;
        if (mw_valid !== 1'b1 || mw_addr !== 24'h100 || w_ready !== 4'b0) begin
            errors++;
            $display("FAIL rr_last_write: got v=%b a=%h ready=%b, required v=1 a=000100 ready=0000", mw_valid, mw_addr, w_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (mw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got write_valid=%b, required 0", mw_valid);
        end
        next_cycle();
    endtask

    task automatic test_write_first();
        do_reset();
        mem_ready  = 1'b1;
        w_addr[2]  = 24'h20;
        w_data[2]  = 32'h55;
        r_addr[2]  = 24'h10;
        w_valid[2] = 1'b1;
        r_valid[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (w_ready !== 4'b0100 || r_ready !== 4'b0000) begin
            errors++;
            $display("FAIL wf_write_first: got w=%b r=%b, required w=0100 r=0000", w_ready, r_ready);
        end
        next_cycle();
        w_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (r_ready !== 4'b0100 || w_ready !== 4'b0000) begin
            errors++;
            $display("FAIL wf_read_next: got w=%b r=%b, required w=0000 r=0100", w_ready, r_ready);
        end
        checks++;
        if (mw_valid !== 1'b1 || mw_addr !== 24'h20 || mw_data !== 32'h55 || mr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wf_memc_write: got v=%b a=%h d=%h rv=%b, required v=1 a=000020 d=00000055 rv=0",
                     mw_valid, mw_addr, mw_data, mr_valid);
        end
        next_cycle();
        r_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (mr_valid !== 1'b1 || mr_addr !== 24'h10 || mw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wf_memc_read: got rv=%b a=%h wv=%b, required rv=1 a=000010 wv=0", mr_valid, mr_addr, mw_valid);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        do_reset();
        mem_ready  = 1'b0;
        w_addr[1]  = 24'h31;
        w_data[1]  = 32'h1111;
        w_valid[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (w_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_first_accept: got %b, required 0010", w_ready);
        end
        next_cycle();
        w_addr[1] = 24'h32;
        w_data[1] = 32'h2222;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (mw_valid !== 1'b1 || mw_addr !== 24'h31 || mw_data !== 32'h1111 || w_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b a=%h d=%h ready=%b, required v=1 a=000031 d=00001111 ready=0000",
                         k, mw_valid, mw_addr, mw_data, w_ready);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (w_ready !== 4'b0010 || mw_addr !== 24'h31) begin
            errors++;
            $display("FAIL stall_release: got ready=%b a=%h, required ready=0010 a=000031", w_ready, mw_addr);
        end
        next_cycle();
        w_valid = '0;
        @(negedge clk);
        checks++;
        if (mw_valid !== 1'b1 || mw_addr !== 24'h32 || mw_data !== 32'h2222) begin
            errors++;
            $display("FAIL stall_second: got v=%b a=%h d=%h, required v=1 a=000032 d=00002222", mw_valid, mw_addr, mw_data);
        end
        next_cycle();
    endtask

    task automatic test_tag_full();
        do_reset();
        mem_ready  = 1'b1;
        r_addr[0]  = 24'h40;
        r_valid[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (r_ready !== 4'b0001) begin
                errors++;
                $display("FAIL full_fill read %0d: got %b, required 0001", k, r_ready);
            end
            next_cycle();
        end
        w_addr[3]  = 24'h77;
        w_data[3]  = 32'h7777;
        w_valid[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (r_ready !== 4'b0000 || w_ready !== 4'b1000) begin
            errors++;
            $display("FAIL full_block: got r=%b w=%b, required r=0000 w=1000", r_ready, w_ready);
        end
        next_cycle();
        w_valid   = '0;
        mem_rdv   = 1'b1;
        mem_rdata = 32'hD0;
        @(negedge clk);
        checks++;
        if (mw_valid !== 1'b1 || mw_addr !== 24'h77 || r_ready !== 4'b0000) begin
            errors++;
            $display("FAIL full_write_passes: got v=%b a=%h r=%b, required v=1 a=000077 r=0000", mw_valid, mw_addr, r_ready);
        end
        checks++;
        if (d_rvalid !== 4'b0001 || d_rdata !== 32'hD0) begin
            errors++;
            $display("FAIL full_return: got v=%b d=%h, required v=0001 d=000000d0", d_rvalid, d_rdata);
        end
        next_cycle();
        mem_rdv = 1'b0;
        @(negedge clk);
        checks++;
        if (r_ready !== 4'b0001) begin
            errors++;
            $display("FAIL full_resume: got %b, required 0001", r_ready);
        end
        next_cycle();
        r_valid = '0;
    endtask

    task automatic test_return_routing();
        logic [3:0]  lanes [3];
        logic [31:0] rdata [3];
        lanes[0] = 4'b1000; lanes[1] = 4'b0001; lanes[2] = 4'b0010;
        rdata[0] = 32'hD000_0000; rdata[1] = 32'hD111_1111; rdata[2] = 32'hD222_2222;
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r_valid = lanes[k];
            @(negedge clk);
            checks++;
            if (r_ready !== lanes[k]) begin
                errors++;
                $display("FAIL route_issue %0d: got %b, required %b", k, r_ready, lanes[k]);
            end
            next_cycle();
        end
        r_valid = '0;
        for (int k = 0; k < 3; k++) begin
            mem_rdv   = 1'b1;
            mem_rdata = rdata[k];
            @(negedge clk);
            checks++;
            if (d_rvalid !== lanes[k] || d_rdata !== rdata[k]) begin
                errors++;
                $display("FAIL route_return %0d: got v=%b d=%h, required v=%b d=%h", k, d_rvalid, d_rdata, lanes[k], rdata[k]);
            end
            next_cycle();
        end
        mem_rdv = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 4'b0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL route_idle: got v=%b err=%b, required v=0000 err=0", d_rvalid, err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_reset_orphan();
        logic [3:0] exp_ready;
        do_reset();
        mem_ready = 1'b1;
        r_valid   = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_ready = 4'b0001 << k;
            checks++;
            if (r_ready !== exp_ready) begin
                errors++;
                $display("FAIL orphan_issue %0d: got %b, required %b", k, r_ready, exp_ready);
            end
            next_cycle();
        end
        r_valid = '0;
        reset_poweron = 1'b0;
        #1;
        checks++;
        if (mr_valid !== 1'b0 || r_ready !== 4'b0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_async_reset: got rv=%b ready=%b err=%b, required 0 0000 0", mr_valid, r_ready, err_orphan);
        end
        @(negedge clk);
        reset_poweron = 1'b1;
        next_cycle();
        mem_rdv   = 1'b1;
        mem_rdata = 32'hBEEF;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 4'b0) begin
            errors++;
            $display("FAIL orphan_dropped: got %b, required 0000", d_rvalid);
        end
        next_cycle();
        mem_rdv = 1'b0;
        @(negedge clk);
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_flag: got %b, required 1", err_orphan);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: got %b, required 1", err_orphan);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_first();
        test_stall();
        test_tag_full();
        test_return_routing();
        test_reset_orphan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
